// File: rtl/sequence_generator.sv
// Emits the 8-symbol detection pattern over a valid/ready link, repeated for a
// latched number of passes with optional idle gaps and one optionally corrupted position.
module sequence_generator #(
    parameter int SYM_W      = 3,
    parameter int SEQ_LEN    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       repeat_cnt,
    input  logic             corrupt_en,
    input  logic [2:0]       corrupt_idx,
    input  logic             data_ready,
    output logic [SYM_W-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       sym_idx,
    output logic [1:0]       fsm_state
);

    // Handshake: a symbol moves on a rising edge where data_valid and data_ready
    // are both 1; while data_valid=1 and data_ready=0, data_out and sym_idx hold,
    // and data_valid never drops until the pass completes.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [2:0]     LAST_IDX = 3'(SEQ_LEN - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t        state;
    state_t        next_state;
    logic [7:0]    pass_left;
    logic [GW-1:0] gap_cnt;
    logic          cfg_corrupt_en;
    logic [2:0]    cfg_corrupt_idx;
    logic          xfer;
    logic          pass_end;
    logic          last_pass;
    logic [2:0]    sym;

    function automatic logic [2:0] pattern(input logic [2:0] idx);
        case (idx)
            3'd0:    pattern = 3'b001;
            3'd1:    pattern = 3'b101;
            3'd2:    pattern = 3'b110;
            3'd3:    pattern = 3'b000;
            3'd4:    pattern = 3'b110;
            3'd5:    pattern = 3'b110;
            3'd6:    pattern = 3'b011;
            default: pattern = 3'b101;
        endcase
    endfunction

    assign xfer      = (state == SEND) && data_ready;
    assign pass_end  = xfer && (sym_idx == LAST_IDX);
    assign last_pass = (pass_left <= 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) next_state = SEND;
            end
            SEND: begin
                if (pass_end) begin
                    if (last_pass)            next_state = IDLE;
                    else if (GAP_CYCLES > 0)  next_state = GAP;
                    else                      next_state = SEND;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) next_state = SEND;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: symbol index, remaining passes, gap timer, latched config, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_idx         <= 3'd0;
            pass_left       <= 8'd0;
            gap_cnt         <= '0;
            cfg_corrupt_en  <= 1'b0;
            cfg_corrupt_idx <= 3'd0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sym_idx         <= 3'd0;
                        pass_left       <= (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
                        cfg_corrupt_en  <= corrupt_en;
                        cfg_corrupt_idx <= corrupt_idx;
                    end
                end
                SEND: begin
                    if (pass_end) begin
                        sym_idx   <= 3'd0;
                        gap_cnt   <= '0;
                        pass_left <= pass_left - 8'd1;
                        done      <= last_pass;
                    end else if (xfer) begin
                        sym_idx <= sym_idx + 3'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_valid = 1'b0;
        busy       = 1'b0;
        data_out   = '0;
        sym        = pattern(sym_idx);
        if (cfg_corrupt_en && (sym_idx == cfg_corrupt_idx)) sym = ~sym;
        case (state)
            SEND: begin
                data_valid = 1'b1;
                busy       = 1'b1;
                data_out   = SYM_W'(sym);
            end
            GAP: begin
                busy = 1'b1;
            end
            default: ;
        endcase
        fsm_state = state;
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: randomized handshakes checked against a
// queue of expected symbols built directly from the pattern, pass count and corruption rule.
module tb_sequence_generator;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] repeat_cnt;
    logic       corrupt_en;
    logic [2:0] corrupt_idx;
    logic       data_ready;
    logic [2:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       done;
    logic [2:0] sym_idx;
    logic [1:0] fsm_state;

    int tests = 0;
    int fails = 0;
    logic [2:0] exp_q[$];
    logic [2:0] pat[8] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};

    sequence_generator #(.SYM_W(3), .SEQ_LEN(8), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .start(start), .repeat_cnt(repeat_cnt),
        .corrupt_en(corrupt_en), .corrupt_idx(corrupt_idx), .data_ready(data_ready),
        .data_out(data_out), .data_valid(data_valid), .busy(busy), .done(done),
        .sym_idx(sym_idx), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a start request and build the expected symbol stream for it.
    task automatic start_seq(input int rc, input bit cen, input int cidx);
        int passes;
        logic [2:0] s;
        repeat_cnt  = 8'(rc);
        corrupt_en  = cen;
        corrupt_idx = 3'(cidx);
        start       = 1'b1;
        passes = (rc == 0) ? 1 : rc;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 8; i++) begin
                s = pat[i];
                if (cen && i == cidx) s = s ^ 3'b111;
                exp_q.push_back(s);
            end
        end
    endtask

    // Runs from the start edge through the done cycle; returns cycles until done.
    task automatic run_body(input int ready_pct, input bit stall3, input bit poke4, output int cyc);
        int pos;
        int gap;
        int stalls;
        int budget;
        bit rdy;
        bit xfer;
        pos = 0; gap = 0; stalls = 0; cyc = 0;
        budget = 20 * exp_q.size() + 50;
        data_ready = 1'b1;
        step();
        cyc++;
        start = 1'b0;
        repeat_cnt  = 8'($urandom_range(0, 255));
        corrupt_en  = 1'($urandom_range(0, 1));
        corrupt_idx = 3'($urandom_range(0, 7));
        check("first_valid", 32'(data_valid), 32'd1);
        while (exp_q.size() > 0 && cyc < budget) begin
            start = 1'b0;
            if (data_valid) begin
                check("sym", 32'(data_out), 32'(exp_q[0]));
                check("sym_idx", 32'(sym_idx), 32'(pos));
                check("busy_send", 32'(busy), 32'd1);
                if (gap > 0) check("gap_len", 32'(gap), 32'(GAP));
                gap = 0;
            end else begin
                check("valid_drop_pos", 32'(pos), 32'd0);
                check("busy_gap", 32'(busy), 32'd1);
                check("data_gap", 32'(data_out), 32'd0);
                gap++;
            end
            check("no_early_done", 32'(done), 32'd0);
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (stall3 && data_valid && pos == 3 && stalls < 3) begin
                rdy = 1'b0;
                stalls++;
            end
            if (poke4 && data_valid && pos == 4) begin
                start       = 1'b1;
                repeat_cnt  = 8'd9;
                corrupt_en  = 1'b1;
                corrupt_idx = 3'd0;
            end
            data_ready = rdy;
            xfer = data_valid && rdy;
            step();
            cyc++;
            if (xfer) begin
                void'(exp_q.pop_front());
                pos = (pos + 1) % 8;
            end
        end
        start = 1'b0;
        if (exp_q.size() > 0) begin
            check("timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_valid", 32'(data_valid), 32'd0);
        check("done_data", 32'(data_out), 32'd0);
    endtask

    task automatic after_done();
        step();
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(data_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        int guard;
        reset = 1'b1; start = 1'b0; repeat_cnt = 8'd0; corrupt_en = 1'b0;
        corrupt_idx = 3'd0; data_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(sym_idx), 32'd0);

        // Single pass, always ready: done at N+9.
        start_seq(1, 0, 0);
        run_body(100, 0, 0, cyc);
        check("latency_1pass", 32'(cyc), 32'd9);
        after_done();

        // Three-cycle stall at position 3 delays done by 3.
        start_seq(1, 0, 0);
        run_body(100, 1, 0, cyc);
        check("latency_stall", 32'(cyc), 32'd12);
        after_done();

        // Two passes with a gap, then repeat_cnt=0 meaning one pass.
        start_seq(2, 0, 0);
        run_body(100, 0, 0, cyc);
        check("latency_2pass", 32'(cyc), 32'(16 + GAP + 1));
        after_done();
        start_seq(0, 0, 0);
        run_body(100, 0, 0, cyc);
        check("latency_rc0", 32'(cyc), 32'd9);
        after_done();

        // Corruption of position 2 over two passes.
        start_seq(2, 1, 2);
        run_body(100, 0, 0, cyc);
        after_done();

        // Start while busy is ignored.
        start_seq(1, 0, 0);
        run_body(100, 0, 1, cyc);
        check("latency_poke", 32'(cyc), 32'd9);
        after_done();

        // Start in the done cycle chains straight into a new sequence.
        start_seq(1, 0, 0);
        run_body(100, 0, 0, cyc);
        start_seq(2, 1, 5);
        run_body(70, 0, 0, cyc);
        after_done();

        // Randomized configurations and backpressure.
        for (int t = 0; t < 8; t++) begin
            start_seq(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 7)));
            run_body(int'($urandom_range(25, 100)), 0, 1'($urandom_range(0, 1)), cyc);
            after_done();
        end

        // Maximum pass count.
        start_seq(255, 0, 0);
        run_body(100, 0, 0, cyc);
        check("latency_255", 32'(cyc), 32'(255 * 8 + 254 * GAP + 1));
        after_done();

        // Reset mid-sequence at position 5 aborts with no done.
        start_seq(3, 0, 0);
        exp_q.delete();
        data_ready = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (sym_idx != 3'd5 && guard < 20) begin
            step();
            guard++;
        end
        check("reach_idx5", 32'(sym_idx), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_data", 32'(data_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_idx", 32'(sym_idx), 32'd0);
        step();
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_stay_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Transmit-side counterpart to the sequence detector. On a start request it emits the fixed 8-symbol, 3-bit detection pattern 001,101,110,000,110,110,011,101 using a valid/ready handshake. Emission repeats a programmable number of passes, with optional idle gaps between passes. It can deliberately corrupt one symbol position so that benches and links can exercise the detector's negative path.

Parameters:
SYM_W, 3, symbol width in bits (pattern table is defined for 3).
SEQ_LEN, 8, number of symbols per pass.
GAP_CYCLES, 2, idle cycles between passes (0 = back-to-back passes).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request to begin; sampled only in IDLE.
repeat_cnt  input  8  number of passes, latched at start; 0 treated as 1.
corrupt_en  input  1  latched at start; enables symbol corruption.
corrupt_idx  input  3  latched at start; pattern position (0..7) to corrupt.
data_ready  input  1  sink can accept data_out this cycle.
data_out  output  SYM_W  current symbol.
data_valid  output  1  data_out holds a pattern symbol.
busy  output  1  high in SEND and GAP.
done  output  1  one-cycle pulse after the final handshake of the final pass.
sym_idx  output  3  index of the symbol currently presented.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Port names are clk and reset.
- Reset values: data_out=000, data_valid=0, busy=0, done=0, sym_idx=0. Pass counter and latched config are cleared. State is IDLE.
- Reset has priority over every other input in the same cycle.
- A reset asserted mid-sequence aborts the sequence immediately. No done pulse is produced.
- States:
  - IDLE: data_valid=0, data_out=000.
  - SEND: data_valid=1.
  - GAP: data_valid=0, data_out=000, counts GAP_CYCLES.
- IDLE -> SEND:
  - Triggered when start=1 at edge N.
  - Config is latched at that edge.
  - From cycle N+1: data_valid=1, sym_idx=0, data_out=001.
- Start is ignored while busy.
- Handshake:
  - A symbol transfers on an edge where data_valid and data_ready are both 1.
  - sym_idx then advances by 1.
  - data_out and sym_idx hold stable while data_valid=1 and data_ready=0.
  - data_valid never drops mid-pass.
- Throughput: with data_ready held high, one symbol per cycle, so 8 consecutive cycles per pass.
- End of pass (handshake at sym_idx=7):
  - If passes remain and GAP_CYCLES>0: go to GAP, then to SEND with sym_idx=0 after exactly GAP_CYCLES cycles.
  - If passes remain and GAP_CYCLES=0: stay in SEND, wrap sym_idx to 0, no bubble.
  - If it is the last pass: go to IDLE. done=1 for the following cycle only and busy=0 in that cycle.
- A start sampled in the same cycle as done is accepted.
- Corruption:
  - Applies when corrupt_en is latched at 1.
  - The symbol at corrupt_idx is emitted XOR 111 on every pass.
  - All other symbols are unchanged.
- Pass counter is 8-bit and holds the remaining passes. repeat_cnt=255 produces 255 passes.

Test Plan:
1. Reset, then start with repeat_cnt=1, corrupt_en=0, data_ready=1 -> data_out 001,101,110,000,110,110,011,101 on cycles N+1..N+8. done pulses at N+9; busy falls at N+9.
2. Same as 1 but data_ready=0 for 3 cycles while sym_idx=3 -> data_out holds 000 and sym_idx holds 3 for 3 cycles. Sequence then completes with no lost or duplicated symbols; done is delayed by 3 cycles.
3. repeat_cnt=2, GAP_CYCLES=2 -> 8 symbols, 2 cycles with data_valid=0, 8 symbols, then a single done pulse. With repeat_cnt=0 -> exactly 1 pass.
4. corrupt_en=1, corrupt_idx=2 -> third symbol is 001 (110 XOR 111), all others nominal. A downstream sequence detector never asserts sequence_found.
5. Assert start again at sym_idx=4 -> ignored, sequence unaffected. Assert reset at sym_idx=5 -> next cycle data_valid=0, data_out=000, busy=0, no done pulse.
6. Assert start in the done cycle -> a new pass begins the next cycle with data_out=001.
